// File: rtl/multicycle_controller.sv
// ----------------------------------------------------------------------------
// multicycle_controller
//   Main control FSM of the multicycle RV32I core. It sequences the shared ALU,
//   the register file and the unified instruction/data memory port over several
//   cycles per instruction (lw, sw, R-type, I-type ALU, beq, jal). It waits on a
//   req/ready memory handshake, traps on illegal instructions and on memory
//   accesses that never complete, and counts retired instructions.
//
// Parameters
//   MAX_WAIT   cycles an access may wait for mem_ready before trapping (1..255)
//   INSTRET_W  width of the retired-instruction counter
//
// Ports
//   clk, reset                 rising-edge clock, synchronous active-high reset
//   opcode/funct3/funct7b5     instruction fields from the instruction register
//   zero                       ALU zero flag (beq outcome)
//   mem_ready                  memory completes the current access this cycle
//   mem_req/mem_write/adr_src  memory request, store qualifier, address select
//   IR_write/PC_write/reg_write  architectural state strobes
//   result_src/ALU_src_A/ALU_src_B/imm_src/ALU_control  datapath selects
//   error/err_cause            sticky trap flag and its cause (01 illegal, 10 timeout)
//   instret                    retired-instruction count, wraps modulo 2^INSTRET_W
// ----------------------------------------------------------------------------
module multicycle_controller #(
  parameter int unsigned MAX_WAIT  = 255,
  parameter int unsigned INSTRET_W = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [6:0]           opcode,
  input  logic [2:0]           funct3,
  input  logic                 funct7b5,
  input  logic                 zero,
  input  logic                 mem_ready,
  output logic                 mem_req,
  output logic                 mem_write,
  output logic                 adr_src,
  output logic                 IR_write,
  output logic                 PC_write,
  output logic                 reg_write,
  output logic [1:0]           result_src,
  output logic [1:0]           ALU_src_A,
  output logic [1:0]           ALU_src_B,
  output logic [1:0]           imm_src,
  output logic [3:0]           ALU_control,
  output logic                 error,
  output logic [1:0]           err_cause,
  output logic [INSTRET_W-1:0] instret
);

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_SUB = 4'b0001;
  localparam logic [3:0] ALU_AND = 4'b0010;
  localparam logic [3:0] ALU_OR  = 4'b0011;
  localparam logic [3:0] ALU_SLT = 4'b0101;

  localparam logic [1:0] CAUSE_ILLEGAL = 2'b01;
  localparam logic [1:0] CAUSE_TIMEOUT = 2'b10;

  // Last wait count before the access is declared dead.
  localparam logic [7:0] WAIT_LAST = 8'(MAX_WAIT - 1);

  localparam logic [INSTRET_W-1:0] INSTRET_ONE = {{(INSTRET_W-1){1'b0}}, 1'b1};

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE,
    S_EXECR, S_EXECI, S_ALUWB, S_BEQ, S_JAL, S_ERR
  } state_t;

  state_t                 state_q, state_d;
  logic [7:0]             wait_cnt_q, wait_cnt_d;
  logic [INSTRET_W-1:0]   instret_q, instret_d;
  logic                   error_q, error_d;
  logic [1:0]             err_cause_q, err_cause_d;

  logic                   timeout;
  logic [1:0]             imm_dec;

  function automatic logic funct3_legal(input logic [2:0] f3);
    return (f3 == 3'b000) || (f3 == 3'b010) || (f3 == 3'b110) || (f3 == 3'b111);
  endfunction

  function automatic logic [3:0] alu_decode(input logic [2:0] f3, input logic use_sub);
    logic [3:0] code;
    case (f3)
      3'b000:  code = use_sub ? ALU_SUB : ALU_ADD;
      3'b010:  code = ALU_SLT;
      3'b110:  code = ALU_OR;
      3'b111:  code = ALU_AND;
      default: code = ALU_ADD;
    endcase
    return code;
  endfunction

  assign timeout = (wait_cnt_q == WAIT_LAST) && !mem_ready;

  // The immediate format follows the instruction, so the extender is already
  // right for MEMADR and EXECI as well as for the target computed in DECODE.
  always_comb begin
    case (opcode)
      OP_SW:   imm_dec = 2'b01;
      OP_BEQ:  imm_dec = 2'b10;
      OP_JAL:  imm_dec = 2'b11;
      default: imm_dec = 2'b00;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    wait_cnt_d  = wait_cnt_q;
    instret_d   = instret_q;
    error_d     = error_q;
    err_cause_d = err_cause_q;
    mem_req     = 1'b0;
    mem_write   = 1'b0;
    adr_src     = 1'b0;
    IR_write    = 1'b0;
    PC_write    = 1'b0;
    reg_write   = 1'b0;
    result_src  = 2'b00;
    ALU_src_A   = 2'b00;
    ALU_src_B   = 2'b00;
    imm_src     = imm_dec;
    ALU_control = ALU_ADD;

    case (state_q)
      S_FETCH: begin
        mem_req = 1'b1;
        if (mem_ready) begin
          // PC <= PC + 4 while the instruction is captured.
          IR_write   = 1'b1;
          PC_write   = 1'b1;
          ALU_src_B  = 2'b10;
          result_src = 2'b10;
          state_d    = S_DECODE;
        end else if (timeout) begin
          state_d     = S_ERR;
          err_cause_d = CAUSE_TIMEOUT;
        end
      end
      S_DECODE: begin
        // Branch/jump target (old PC + imm) lands in ALUOut.
        ALU_src_A = 2'b01;
        ALU_src_B = 2'b01;
        case (opcode)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_R:         state_d = S_EXECR;
          OP_I:         state_d = S_EXECI;
          OP_BEQ:       state_d = S_BEQ;
          OP_JAL:       state_d = S_JAL;
          default: begin
            state_d     = S_ERR;
            err_cause_d = CAUSE_ILLEGAL;
          end
        endcase
      end
      S_MEMADR: begin
        ALU_src_A = 2'b10;
        ALU_src_B = 2'b01;
        state_d   = (opcode == OP_SW) ? S_MEMWRITE : S_MEMREAD;
      end
      S_MEMREAD: begin
        mem_req = 1'b1;
        adr_src = 1'b1;
        if (mem_ready) begin
          state_d = S_MEMWB;
        end else if (timeout) begin
          state_d     = S_ERR;
          err_cause_d = CAUSE_TIMEOUT;
        end
      end
      S_MEMWB: begin
        result_src = 2'b01;
        reg_write  = 1'b1;
        state_d    = S_FETCH;
      end
      S_MEMWRITE: begin
        mem_req   = 1'b1;
        mem_write = 1'b1;
        adr_src   = 1'b1;
        if (mem_ready) begin
          state_d = S_FETCH;
        end else if (timeout) begin
          state_d     = S_ERR;
          err_cause_d = CAUSE_TIMEOUT;
        end
      end
      S_EXECR, S_EXECI: begin
        ALU_src_A = 2'b10;
        ALU_src_B = (state_q == S_EXECR) ? 2'b00 : 2'b01;
        // funct7b5 selects sub only for register-register ops; for addi it is
        // part of the immediate.
        ALU_control = alu_decode(funct3, (state_q == S_EXECR) && funct7b5);
        if (funct3_legal(funct3)) begin
          state_d = S_ALUWB;
        end else begin
          state_d     = S_ERR;
          err_cause_d = CAUSE_ILLEGAL;
        end
      end
      S_ALUWB: begin
        reg_write = 1'b1;
        state_d   = S_FETCH;
      end
      S_BEQ: begin
        ALU_src_A   = 2'b10;
        ALU_control = ALU_SUB;
        PC_write    = zero;
        state_d     = S_FETCH;
      end
      S_JAL: begin
        // PC <= target from ALUOut while the ALU forms old PC + 4 for rd.
        ALU_src_A = 2'b01;
        ALU_src_B = 2'b10;
        PC_write  = 1'b1;
        state_d   = S_ALUWB;
      end
      S_ERR: begin
        state_d = S_ERR;
      end
      default: begin
        state_d = S_FETCH;
      end
    endcase

    if (state_d == S_ERR) begin
      error_d = 1'b1;
    end

    // A state change always starts a fresh wait window; only stalled
    // accesses (which hold their state) accumulate.
    if (state_d != state_q) begin
      wait_cnt_d = 8'd0;
    end else if (mem_req && !mem_ready) begin
      wait_cnt_d = wait_cnt_q + 8'd1;
    end

    if ((state_d == S_FETCH) &&
        ((state_q == S_MEMWB) || (state_q == S_MEMWRITE) ||
         (state_q == S_ALUWB) || (state_q == S_BEQ))) begin
      instret_d = instret_q + INSTRET_ONE;
    end

    // Reset wins over any access in flight: nothing is requested or written.
    if (reset) begin
      mem_req     = 1'b0;
      mem_write   = 1'b0;
      adr_src     = 1'b0;
      IR_write    = 1'b0;
      PC_write    = 1'b0;
      reg_write   = 1'b0;
      result_src  = 2'b00;
      ALU_src_A   = 2'b00;
      ALU_src_B   = 2'b00;
      imm_src     = 2'b00;
      ALU_control = ALU_ADD;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_FETCH;
      wait_cnt_q  <= 8'd0;
      instret_q   <= '0;
      error_q     <= 1'b0;
      err_cause_q <= 2'b00;
    end else begin
      state_q     <= state_d;
      wait_cnt_q  <= wait_cnt_d;
      instret_q   <= instret_d;
      error_q     <= error_d;
      err_cause_q <= err_cause_d;
    end
  end

  assign error     = error_q;
  assign err_cause = err_cause_q;
  assign instret   = instret_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// ----------------------------------------------------------------------------
// tb_multicycle_controller
//   Directed bench for the multicycle control FSM. Each cycle the stimulus
//   sets the inputs and pushes the expected control word for that cycle; a
//   checker on the falling edge pops it and compares it with the DUT outputs.
// ----------------------------------------------------------------------------
module tb_multicycle_controller;

  localparam int unsigned IW = 4;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  logic          clk = 1'b0;
  logic          reset;
  logic [6:0]    opcode;
  logic [2:0]    funct3;
  logic          funct7b5;
  logic          zero;
  logic          mem_ready;
  logic          mem_req, mem_write, adr_src, IR_write, PC_write, reg_write;
  logic [1:0]    result_src, ALU_src_A, ALU_src_B, imm_src;
  logic [3:0]    ALU_control;
  logic          error;
  logic [1:0]    err_cause;
  logic [IW-1:0] instret;

  multicycle_controller #(.MAX_WAIT(4), .INSTRET_W(IW)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .funct3(funct3),
    .funct7b5(funct7b5), .zero(zero), .mem_ready(mem_ready),
    .mem_req(mem_req), .mem_write(mem_write), .adr_src(adr_src),
    .IR_write(IR_write), .PC_write(PC_write), .reg_write(reg_write),
    .result_src(result_src), .ALU_src_A(ALU_src_A), .ALU_src_B(ALU_src_B),
    .imm_src(imm_src), .ALU_control(ALU_control), .error(error),
    .err_cause(err_cause), .instret(instret)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic          mr, mw, adr, ir, pcw, rw;
    logic [1:0]    res, a, b, imm;
    logic [3:0]    alu;
    logic          err;
    logic [1:0]    cause;
    logic [IW-1:0] instret;
    logic          imm_chk;
  } exp_t;

  exp_t    exp_q[$];
  string   tag_q[$];
  int      checks = 0;
  int      errors = 0;

  logic          exp_err     = 1'b0;
  logic [1:0]    exp_cause   = 2'b00;
  logic [IW-1:0] exp_instret = '0;

  // Scoreboard checker: one comparison per queued cycle.
  exp_t  chk_e, chk_o;
  string chk_t;
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      chk_e = exp_q.pop_front();
      chk_t = tag_q.pop_front();
      chk_o = '{mr: mem_req, mw: mem_write, adr: adr_src, ir: IR_write,
                pcw: PC_write, rw: reg_write, res: result_src, a: ALU_src_A,
                b: ALU_src_B, imm: imm_src, alu: ALU_control, err: error,
                cause: err_cause, instret: instret, imm_chk: chk_e.imm_chk};
      if (!chk_e.imm_chk) chk_o.imm = chk_e.imm;
      checks++;
      assert (chk_o === chk_e) else begin
        errors++;
        $error("FAIL %s observed=%h expected=%h", chk_t, chk_o, chk_e);
      end
    end
  end

  function automatic exp_t base();
    exp_t e = '0;
    e.err     = exp_err;
    e.cause   = exp_cause;
    e.instret = exp_instret;
    return e;
  endfunction

  function automatic exp_t f_fetch(input logic rdy);
    exp_t e = base();
    e.mr = 1'b1;
    if (rdy) begin e.ir = 1'b1; e.pcw = 1'b1; e.b = 2'b10; e.res = 2'b10; end
    return e;
  endfunction

  function automatic exp_t f_decode(input logic [1:0] imm);
    exp_t e = base();
    e.a = 2'b01; e.b = 2'b01; e.imm = imm; e.imm_chk = 1'b1;
    return e;
  endfunction

  function automatic exp_t f_memadr();
    exp_t e = base();
    e.a = 2'b10; e.b = 2'b01;
    return e;
  endfunction

  function automatic exp_t f_memread();
    exp_t e = base();
    e.mr = 1'b1; e.adr = 1'b1;
    return e;
  endfunction

  function automatic exp_t f_memwb();
    exp_t e = base();
    e.res = 2'b01; e.rw = 1'b1;
    return e;
  endfunction

  function automatic exp_t f_memwrite();
    exp_t e = base();
    e.mr = 1'b1; e.mw = 1'b1; e.adr = 1'b1;
    return e;
  endfunction

  function automatic exp_t f_exec(input logic is_r, input logic [3:0] alu);
    exp_t e = base();
    e.a = 2'b10; e.b = is_r ? 2'b00 : 2'b01; e.alu = alu;
    return e;
  endfunction

  function automatic exp_t f_aluwb();
    exp_t e = base();
    e.rw = 1'b1;
    return e;
  endfunction

  function automatic exp_t f_beq(input logic z);
    exp_t e = base();
    e.a = 2'b10; e.alu = 4'b0001; e.pcw = z;
    return e;
  endfunction

  function automatic exp_t f_jal();
    exp_t e = base();
    e.a = 2'b01; e.b = 2'b10; e.pcw = 1'b1;
    return e;
  endfunction

  task automatic cyc(input string tag, input exp_t e);
    exp_q.push_back(e);
    tag_q.push_back(tag);
    @(negedge clk);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int n);
    reset = 1'b1;
    for (int i = 0; i < n; i++) begin
      cyc("reset", base());
      exp_err = 1'b0; exp_cause = 2'b00; exp_instret = '0;
    end
    reset = 1'b0;
  endtask

  task automatic fetch_decode(input logic [6:0] op, input logic [2:0] f3,
                              input logic f7, input logic [1:0] imm);
    opcode = op; funct3 = f3; funct7b5 = f7;
    mem_ready = 1'b1;
    cyc("fetch", f_fetch(1'b1));
    mem_ready = 1'b0;
    cyc("decode", f_decode(imm));
  endtask

  initial begin
    reset = 1'b1; opcode = '0; funct3 = '0; funct7b5 = 1'b0;
    zero = 1'b0; mem_ready = 1'b0;
    @(posedge clk);
    #1;
    do_reset(2);

    #1;
    checks++;
    if (mem_req !== 1'b1 || mem_write !== 1'b0 || IR_write !== 1'b0 ||
        PC_write !== 1'b0 || reg_write !== 1'b0 || error !== 1'b0 ||
        err_cause !== 2'b00 || instret !== '0) begin
      errors++;
      $error("FAIL reset_state mem_req=%b error=%b err_cause=%b instret=%h",
             mem_req, error, err_cause, instret);
    end

    // lw with two stall cycles in FETCH and in MEMREAD
    opcode = OP_LW; funct3 = 3'b010;
    cyc("lw_fetch_wait0", f_fetch(1'b0));
    cyc("lw_fetch_wait1", f_fetch(1'b0));
    mem_ready = 1'b1;
    cyc("lw_fetch", f_fetch(1'b1));
    mem_ready = 1'b0;
    cyc("lw_decode", f_decode(2'b00));
    cyc("lw_memadr", f_memadr());
    cyc("lw_memread_wait0", f_memread());
    cyc("lw_memread_wait1", f_memread());
    mem_ready = 1'b1;
    cyc("lw_memread", f_memread());
    mem_ready = 1'b0;
    cyc("lw_memwb", f_memwb());
    exp_instret++;

    // beq taken then not taken
    fetch_decode(OP_BEQ, 3'b000, 1'b0, 2'b10);
    zero = 1'b1;
    cyc("beq_taken", f_beq(1'b1));
    exp_instret++;
    fetch_decode(OP_BEQ, 3'b000, 1'b0, 2'b10);
    zero = 1'b0;
    cyc("beq_not_taken", f_beq(1'b0));
    exp_instret++;

    // jal
    fetch_decode(OP_JAL, 3'b000, 1'b0, 2'b11);
    cyc("jal", f_jal());
    cyc("jal_aluwb", f_aluwb());
    exp_instret++;

    // sw, zero-wait memory
    fetch_decode(OP_SW, 3'b010, 1'b0, 2'b01);
    cyc("sw_memadr", f_memadr());
    mem_ready = 1'b1;
    cyc("sw_memwrite", f_memwrite());
    mem_ready = 1'b0;
    exp_instret++;

    // I-type slt, addi with bit 30 set (must stay add)
    fetch_decode(OP_I, 3'b010, 1'b0, 2'b00);
    cyc("slti_exec", f_exec(1'b0, 4'b0101));
    cyc("slti_aluwb", f_aluwb());
    exp_instret++;
    fetch_decode(OP_I, 3'b000, 1'b1, 2'b00);
    cyc("addi_exec", f_exec(1'b0, 4'b0000));
    cyc("addi_aluwb", f_aluwb());
    exp_instret++;

    // R-type sub, or, and
    fetch_decode(OP_R, 3'b000, 1'b1, 2'b00);
    cyc("sub_exec", f_exec(1'b1, 4'b0001));
    cyc("sub_aluwb", f_aluwb());
    exp_instret++;
    fetch_decode(OP_R, 3'b110, 1'b0, 2'b00);
    cyc("or_exec", f_exec(1'b1, 4'b0011));
    cyc("or_aluwb", f_aluwb());
    exp_instret++;
    fetch_decode(OP_R, 3'b111, 1'b0, 2'b00);
    cyc("and_exec", f_exec(1'b1, 4'b0010));
    cyc("and_aluwb", f_aluwb());
    exp_instret++;

    // R-type with unsupported funct3: trap, no writeback
    fetch_decode(OP_R, 3'b001, 1'b0, 2'b00);
    cyc("r_illegal_exec", f_exec(1'b1, 4'b0000));
    exp_err = 1'b1; exp_cause = 2'b01;
    for (int i = 0; i < 3; i++) cyc("r_illegal_err", base());
    do_reset(1);

    // illegal opcode: ERR is sticky for 100 cycles, then reset clears it
    fetch_decode(7'h7F, 3'b000, 1'b0, 2'b00);
    exp_err = 1'b1; exp_cause = 2'b01;
    mem_ready = 1'b1;
    for (int i = 0; i < 100; i++) cyc("illegal_op_err", base());
    mem_ready = 1'b0;
    do_reset(1);
    cyc("after_reset_fetch", f_fetch(1'b0));

    // MEMWRITE timeout: exactly 4 wait cycles, then ERR
    fetch_decode(OP_SW, 3'b010, 1'b0, 2'b01);
    cyc("swto_memadr", f_memadr());
    for (int i = 0; i < 4; i++) cyc("swto_memwrite_wait", f_memwrite());
    exp_err = 1'b1; exp_cause = 2'b10;
    checks++;
    if (error !== 1'b1 || err_cause !== 2'b10 || mem_req !== 1'b0 ||
        mem_write !== 1'b0) begin
      errors++;
      $error("FAIL expired_wait error=%b err_cause=%b mem_req=%b mem_write=%b",
             error, err_cause, mem_req, mem_write);
    end
    cyc("swto_err0", base());
    cyc("swto_err1", base());
    do_reset(1);

    // FETCH timeout
    for (int i = 0; i < 4; i++) cyc("fetchto_wait", f_fetch(1'b0));
    exp_err = 1'b1; exp_cause = 2'b10;
    cyc("fetchto_err", base());
    do_reset(1);

    // reset in the middle of a store access
    fetch_decode(OP_BEQ, 3'b000, 1'b0, 2'b10);
    zero = 1'b0;
    cyc("pre_beq", f_beq(1'b0));
    exp_instret++;
    fetch_decode(OP_SW, 3'b010, 1'b0, 2'b01);
    cyc("midrst_memadr", f_memadr());
    cyc("midrst_memwrite", f_memwrite());
    mem_ready = 1'b1;
    do_reset(1);
    mem_ready = 1'b0;
    cyc("midrst_fetch", f_fetch(1'b0));

    // retired-instruction counter wraps modulo 2^IW
    for (int i = 0; i < 16; i++) begin
      fetch_decode(OP_BEQ, 3'b000, 1'b0, 2'b10);
      cyc("wrap_beq", f_beq(1'b0));
      exp_instret++;
    end
    cyc("wrap_fetch", f_fetch(1'b0));

    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
